// File: rtl/debug_step_ctrl.sv
// Debug run/step/breakpoint controller that gates CPU state updates and arbitrates loader access.
// Optional cycle counter is built only when DBG_CYCLE_CNT_EN is defined.
module debug_step_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             ld_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             cnt_clr,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             ld_gnt,
  output logic             bp_hit,
  output logic             step_done,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_skip;
  logic       r_bp_hit;
  logic       r_step_done;
  logic       w_bp_match;
  logic       w_run_stop;
  logic       w_cpu_en;

  // Skip suppresses the match on the first RUN cycle so a resume at bp_addr makes progress.
  assign w_bp_match = bp_en && (pc == bp_addr) && !r_skip;
  assign w_run_stop = halt_req || w_bp_match;

  always_comb begin
    w_cpu_en = 1'b0;
    case (r_state)
      S_RUN:   w_cpu_en = !w_run_stop;
      S_STEP:  w_cpu_en = 1'b1;
      default: w_cpu_en = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HALT: begin
        if (ld_req)        w_state_nxt = S_LOAD;
        else if (run_req)  w_state_nxt = S_RUN;
        else if (step_req) w_state_nxt = S_STEP;
      end
      S_RUN:   if (w_run_stop) w_state_nxt = S_HALT;
      S_STEP:  w_state_nxt = S_HALT;
      default: if (!ld_req) w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_HALT;
      r_skip      <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_step_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bp_hit    <= (r_state == S_RUN) && w_bp_match;
      r_step_done <= (r_state == S_STEP);
      if ((r_state == S_HALT) && (w_state_nxt == S_RUN))
        r_skip <= 1'b1;
      else if (r_state == S_RUN)
        r_skip <= 1'b0;
    end
  end

  assign cpu_en    = w_cpu_en;
  assign state     = r_state;
  assign ld_gnt    = (r_state == S_LOAD);
  assign bp_hit    = r_bp_hit;
  assign step_done = r_step_done;

`ifdef DBG_CYCLE_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_cnt <= '0;
    else if (cnt_clr)  r_cnt <= '0;
    else if (w_cpu_en) r_cnt <= sat_inc(r_cnt);
  end

  assign cycle_cnt = r_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign cycle_cnt        = '0;
`endif

endmodule

// File: doc/debug_step_ctrl.md
DEBUG_STEP_CTRL -- requirements
Module: debug_step_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32, width of PC and breakpoint address.
REQ-002 SHALL have parameter CNT_W, default 32, width of cycle counter.
REQ-003 SHALL have port clk  input  1  CPU-domain clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port run_req  input  1  request free-running execution.
REQ-006 SHALL have port step_req  input  1  request execution of exactly one instruction.
REQ-007 SHALL have port halt_req  input  1  request stop of free-running execution.
REQ-008 SHALL have port ld_req  input  1  external loader requests IM/DM write access; held high for the whole load.
REQ-009 SHALL have port bp_en  input  1  breakpoint enable.
REQ-010 SHALL have port bp_addr  input  PC_W  breakpoint PC.
REQ-011 SHALL have port pc  input  PC_W  current CPU PC.
REQ-012 SHALL have port cnt_clr  input  1  synchronous clear of cycle_cnt.
REQ-013 SHALL have port cpu_en  output  1  enable for PC, RF and DM writes; CPU state frozen when 0.
REQ-014 SHALL have port state  output  2  FSM state: HALT=00, RUN=01, STEP=10, LOAD=11.
REQ-015 SHALL have port ld_gnt  output  1  loader owns memory write ports.
REQ-016 SHALL have port bp_hit  output  1  one-cycle pulse on breakpoint stop.
REQ-017 SHALL have port step_done  output  1  one-cycle pulse after a step completes.
REQ-018 SHALL have port cycle_cnt  output  CNT_W  count of cycles with cpu_en=1.

Function
REQ-019 HALT: ld_req -> LOAD; else run_req -> RUN; else step_req -> STEP; priority ld_req > run_req > step_req.
REQ-020 RUN: halt_req or breakpoint match -> HALT in the same cycle; run_req/step_req/ld_req ignored.
REQ-021 Breakpoint match SHALL be bp_en=1 and pc==bp_addr and skip flag clear.
REQ-022 Skip flag SHALL set on every HALT->RUN transition and clear after the first RUN cycle, so resuming at bp_addr executes that instruction.
REQ-023 cpu_en SHALL be combinational: 1 in RUN unless halt_req or breakpoint match that cycle; 1 in STEP; 0 in HALT and LOAD.
REQ-024 A stopped instruction (halt or breakpoint) SHALL NOT execute; pc holds its value.
REQ-025 STEP SHALL last exactly one cycle with cpu_en=1, then -> HALT; halt_req, bp match and all requests ignored in STEP.
REQ-026 step_done SHALL be registered, high for the one cycle following the STEP cycle.
REQ-027 bp_hit SHALL be registered, high for the one cycle following a breakpoint-stopped RUN cycle, including when halt_req coincides.
REQ-028 LOAD: ld_gnt=1 combinationally; ld_req=0 -> HALT; no other exit.
REQ-029 cycle_cnt SHALL increment by 1 on each edge where cpu_en=1, saturate at all-ones, and clear on cnt_clr; cnt_clr wins over increment.
REQ-030 Requests SHALL be level-sampled each edge; held run_req/step_req cause one new transition per HALT visit.

Reset
REQ-031 rstn=0 SHALL immediately force state=HALT, cpu_en=0, ld_gnt=0, bp_hit=0, step_done=0, cycle_cnt=0, skip flag=0, regardless of current state.
REQ-032 First transition after rstn deasserts SHALL occur on the first rising clk edge with rstn=1.

Configuration
REQ-033 Macro DBG_CYCLE_CNT_EN defined: cycle counter per REQ-029 present.
REQ-034 DBG_CYCLE_CNT_EN undefined: no counter flops; cycle_cnt tied to 0; cnt_clr ignored; all other behaviour unchanged.

Verification
REQ-035 Reset then step_req 1 cycle, pc=0x1c000000 -> STEP one cycle with cpu_en=1, then HALT, step_done=1 one cycle, cycle_cnt=1.
REQ-036 bp_en=1, bp_addr=0x1c000010, run_req from pc=0x1c000000 -> cpu_en=1 for 4 cycles, stop with pc=0x1c000010, bp_hit pulse, cycle_cnt=4.
REQ-037 From that stop, run_req -> first RUN cycle cpu_en=1 at pc=0x1c000010 (skip), execution continues past it.
REQ-038 HALT with run_req=step_req=ld_req=1 -> LOAD, ld_gnt=1, cpu_en=0; drop ld_req -> HALT next edge.
REQ-039 RUN, rstn pulsed low mid-cycle -> state=00, cpu_en=0, cycle_cnt=0 without waiting for clk.
REQ-040 DBG_CYCLE_CNT_EN defined, counter preloaded all-ones via forced state, RUN 3 cycles -> cycle_cnt stays 0xFFFFFFFF; cnt_clr with cpu_en=1 -> 0.
